// File: rtl/batalha_pkg.sv
// Shared types and constants for the fleet-placement phase.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package batalha_pkg;

    localparam logic [2:0] TIPO_SUBMARINO    = 3'd0;
    localparam logic [2:0] TIPO_CRUZADOR     = 3'd1;
    localparam logic [2:0] TIPO_HIDROAVIAO   = 3'd2;
    localparam logic [2:0] TIPO_ENCOURACADO  = 3'd3;
    localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd4;

    // Pieces per player in the fixed fleet.
    localparam int TOTAL_FROTA = 11;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PEDINDO = 3'd1,
        AVANCA  = 3'd2,
        TROCA   = 3'd3,
        PRONTO  = 3'd4
    } estado_t;

    // QTD table {5,2,2,1,1}; any type past the carrier has no pieces left.
    function automatic logic [2:0] qtd_de(input logic [2:0] t);
        case (t)
            TIPO_SUBMARINO:    return 3'd5;
            TIPO_CRUZADOR:     return 3'd2;
            TIPO_HIDROAVIAO:   return 3'd2;
            TIPO_ENCOURACADO:  return 3'd1;
            TIPO_PORTA_AVIOES: return 3'd1;
            default:           return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/contador_frota.sv
// Piece-type / per-type count tracker with remaining-count and end-of-fleet decode.
// Latency: tipo/qtd update one cycle after an avanca or limpar strobe; restante/frota_fim are combinational.
// Backpressure: none; strobes are gated by the caller, so the counter simply holds when idle.
module contador_frota
    import batalha_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       avanca,
    input  logic       limpar,
    output logic [2:0] tipo,
    output logic [2:0] restante,
    output logic       frota_fim
);

    logic [2:0] qtd;
    logic [2:0] qtd_lim;
    logic [2:0] qtd_inc;
    logic       tipo_fim;

    // Decode the current type's quota and whether the piece being stored finishes it.
    always_comb begin
        qtd_lim   = qtd_de(tipo);
        qtd_inc   = qtd + 3'd1;
        tipo_fim  = (qtd_inc == qtd_lim);
        frota_fim = tipo_fim && (tipo == TIPO_PORTA_AVIOES);
        restante  = qtd_lim - qtd;
    end

    // Advance count within a type, rolling to the next type once its quota is met.
    // After the carrier tipo moves past the table, which reads as zero remaining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tipo <= TIPO_SUBMARINO;
            qtd  <= 3'd0;
        end else if (limpar) begin
            tipo <= TIPO_SUBMARINO;
            qtd  <= 3'd0;
        end else if (avanca) begin
            if (tipo_fim) begin
                tipo <= tipo + 3'd1;
                qtd  <= 3'd0;
            end else begin
                qtd  <= qtd_inc;
            end
        end
    end

endmodule

// File: rtl/agendador_frota.sv
// Fleet-placement sequencer: one placement request per piece, player 0 then player 1, then ready.
// Latency: pedido drops the cycle after peca_ok and returns one cycle later (two across the player swap).
// Backpressure: enable low freezes everything and masks pedido at once; pulses seen while frozen are dropped.
module agendador_frota
    import batalha_pkg::*;
#(
    parameter int RETRY_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic       peca_ok,
    input  logic       conflito_ev,
    output logic       pedido,
    output logic [2:0] tipo,
    output logic       jogador,
    output logic       cpu_vez,
    output logic [2:0] restante,
    output logic       resemear,
    output logic       ready
);

    estado_t    estado, estado_n;
    logic       modo_q, modo_n;
    logic       jogador_n;
    logic [3:0] retry_q, retry_n, retry_inc;
    logic       pedido_q, pedido_n;
    logic       resemear_n;
    logic       ready_n;
    logic       avanca;
    logic       limpar;
    logic       frota_fim;

    contador_frota u_contador (
        .clk      (clk),
        .reset    (reset),
        .avanca   (avanca),
        .limpar   (limpar),
        .tipo     (tipo),
        .restante (restante),
        .frota_fim(frota_fim)
    );

    // Decoded outputs and counter strobes; strobes only fire while running.
    always_comb begin
        pedido    = pedido_q & enable;
        cpu_vez   = jogador & ~modo_q;
        avanca    = enable && (estado == AVANCA);
        limpar    = enable && (estado == TROCA);
        retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    end

    // Next-state and next-output logic; everything holds while enable is low.
    always_comb begin
        estado_n   = estado;
        modo_n     = modo_q;
        jogador_n  = jogador;
        retry_n    = retry_q;
        pedido_n   = pedido_q;
        resemear_n = 1'b0;
        ready_n    = ready;
        if (enable) begin
            case (estado)
                OCIOSO: begin
                    modo_n   = mode;
                    estado_n = PEDINDO;
                    pedido_n = 1'b1;
                end
                PEDINDO: begin
                    if (peca_ok) begin
                        estado_n = AVANCA;
                        pedido_n = 1'b0;
                        retry_n  = 4'd0;
                    end else if (conflito_ev) begin
                        // Human turns keep counting but never ask for a reseed.
                        if (cpu_vez && (int'(retry_inc) == RETRY_MAX)) begin
                            resemear_n = 1'b1;
                            retry_n    = 4'd0;
                        end else begin
                            retry_n    = retry_inc;
                        end
                    end
                end
                AVANCA: begin
                    if (frota_fim) begin
                        if (!jogador) begin
                            estado_n = TROCA;
                        end else begin
                            estado_n = PRONTO;
                            ready_n  = 1'b1;
                        end
                    end else begin
                        estado_n = PEDINDO;
                        pedido_n = 1'b1;
                    end
                end
                TROCA: begin
                    jogador_n = 1'b1;
                    estado_n  = PEDINDO;
                    pedido_n  = 1'b1;
                end
                PRONTO: begin
                    ready_n  = 1'b1;
                    pedido_n = 1'b0;
                end
                default: begin
                    estado_n = OCIOSO;
                    pedido_n = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            modo_q   <= 1'b0;
            jogador  <= 1'b0;
            retry_q  <= 4'd0;
            pedido_q <= 1'b0;
            resemear <= 1'b0;
            ready    <= 1'b0;
        end else begin
            estado   <= estado_n;
            modo_q   <= modo_n;
            jogador  <= jogador_n;
            retry_q  <= retry_n;
            pedido_q <= pedido_n;
            resemear <= resemear_n;
            ready    <= ready_n;
        end
    end

endmodule

// File: tb/tb_agendador_frota.sv
// Directed bench for agendador_frota: full fleets in both modes, reseed, enable hold, async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after a change.
// Expected values come from fixed fleet tables in this file.
module tb_agendador_frota;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       mode;
    logic       peca_ok;
    logic       conflito_ev;
    logic       pedido;
    logic [2:0] tipo;
    logic       jogador;
    logic       cpu_vez;
    logic [2:0] restante;
    logic       resemear;
    logic       ready;

    int checks = 0;
    int errors = 0;

    int exp_tipo [11] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 4};
    int exp_rest [11] = '{5, 4, 3, 2, 1, 2, 1, 2, 1, 1, 1};

    agendador_frota #(.RETRY_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .peca_ok    (peca_ok),
        .conflito_ev(conflito_ev),
        .pedido     (pedido),
        .tipo       (tipo),
        .jogador    (jogador),
        .cpu_vez    (cpu_vez),
        .restante   (restante),
        .resemear   (resemear),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pedido"},   int'(pedido),   0);
        check({tag, "_tipo"},     int'(tipo),     0);
        check({tag, "_jogador"},  int'(jogador),  0);
        check({tag, "_cpu_vez"},  int'(cpu_vez),  0);
        check({tag, "_restante"}, int'(restante), 5);
        check({tag, "_resemear"}, int'(resemear), 0);
        check({tag, "_ready"},    int'(ready),    0);
    endtask

    task automatic wait_pedido();
        int n = 0;
        while (pedido !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pedido_wait", int'(pedido), 1);
    endtask

    task automatic reset_dut(input logic m);
        @(negedge clk);
        reset       = 1'b0;
        enable      = 1'b0;
        peca_ok     = 1'b0;
        conflito_ev = 1'b0;
        mode        = m;
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("start_pedido", int'(pedido), 1);
    endtask

    // n conflicts on the current piece; a reseed is expected only on the 8th when reseed=1.
    task automatic conflicts(input int n, input bit reseed, input int et, input int er);
        for (int c = 1; c <= n; c++) begin
            conflito_ev = 1'b1;
            @(negedge clk);
            conflito_ev = 1'b0;
            check("conf_resemear", int'(resemear), (reseed && c == 8) ? 1 : 0);
            @(negedge clk);
            check("conf_resemear_low", int'(resemear), 0);
        end
        check("conf_pedido",   int'(pedido),   1);
        check("conf_tipo",     int'(tipo),     et);
        check("conf_restante", int'(restante), er);
    endtask

    task automatic enable_drop(input int et, input int er);
        enable = 1'b0;
        #1;
        check("drop_pedido_now", int'(pedido), 0);
        @(negedge clk);
        peca_ok = 1'b1;
        @(negedge clk);
        peca_ok = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_pedido_held", int'(pedido),   0);
        check("drop_tipo",        int'(tipo),     et);
        check("drop_restante",    int'(restante), er);
        enable = 1'b1;
        #1;
        check("drop_pedido_back", int'(pedido),   1);
        check("drop_tipo_back",   int'(tipo),     et);
        check("drop_rest_back",   int'(restante), er);
    endtask

    task automatic run_fleet(input logic m, input int stop, input bit extras, input bit drop);
        int i;
        int j;
        int cpu;
        for (int k = 0; k < stop; k++) begin
            i   = k % 11;
            j   = (k >= 11) ? 1 : 0;
            cpu = (m == 1'b0 && j == 1) ? 1 : 0;
            wait_pedido();
            check("tipo",     int'(tipo),     exp_tipo[i]);
            check("jogador",  int'(jogador),  j);
            check("cpu_vez",  int'(cpu_vez),  cpu);
            check("restante", int'(restante), exp_rest[i]);
            if (drop && k == 6)    enable_drop(exp_tipo[i], exp_rest[i]);
            if (extras && k == 2)  conflicts(8, 1'b0, exp_tipo[i], exp_rest[i]);
            if (extras && k == 13) conflicts(8, 1'b1, exp_tipo[i], exp_rest[i]);
            if (extras && k == 15) conflicts(7, 1'b0, exp_tipo[i], exp_rest[i]);
            if (extras && k == 16) conflicts(1, 1'b0, exp_tipo[i], exp_rest[i]);
            @(negedge clk);
            peca_ok = 1'b1;
            if (extras && k == 15) conflito_ev = 1'b1;
            @(negedge clk);
            peca_ok     = 1'b0;
            conflito_ev = 1'b0;
            check("gap_pedido",   int'(pedido),   0);
            check("gap_resemear", int'(resemear), 0);
            if (k == 10) begin
                @(negedge clk);
                check("troca_pedido", int'(pedido), 0);
            end
            if (k == 21) begin
                check("ready_early", int'(ready), 0);
                @(negedge clk);
                check("ready",        int'(ready),  1);
                check("ready_pedido", int'(pedido), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        mode        = 1'b0;
        peca_ok     = 1'b0;
        conflito_ev = 1'b0;

        // Player vs player, with an enable hold partway through player 0.
        reset_dut(1'b1);
        run_fleet(1'b1, 22, 1'b0, 1'b1);

        // Pulses after ready are ignored.
        @(negedge clk);
        peca_ok     = 1'b1;
        conflito_ev = 1'b1;
        @(negedge clk);
        peca_ok     = 1'b0;
        conflito_ev = 1'b0;
        @(negedge clk);
        check("pronto_ready",    int'(ready),    1);
        check("pronto_pedido",   int'(pedido),   0);
        check("pronto_resemear", int'(resemear), 0);

        // Player vs CPU with conflict bursts and a simultaneous peca_ok/conflito_ev.
        reset_dut(1'b0);
        run_fleet(1'b0, 22, 1'b1, 1'b0);

        // Async reset during player 1's seaplanes.
        reset_dut(1'b0);
        run_fleet(1'b0, 18, 1'b0, 1'b0);
        wait_pedido();
        check("pre_rst_tipo",    int'(tipo),    2);
        check("pre_rst_jogador", int'(jogador), 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_tipo",     int'(tipo),     0);
        check("rel_jogador",  int'(jogador),  0);
        check("rel_restante", int'(restante), 5);
        check("rel_pedido",   int'(pedido),   0);
        @(negedge clk);
        check("rel_restart",  int'(pedido),   1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
